// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths and the arbiter state encoding.
package wb_pkg;
  localparam int WB_ADR_W = 4;
  localparam int WB_DAT_W = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Signal bundle around wb_arbiter: two controller ports plus the shared peripheral bus.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic                m0_we, m1_we;
  logic [WB_ADR_W-1:0] m0_adr, m1_adr;
  logic [WB_DAT_W-1:0] m0_dat_w, m1_dat_w;
  logic                m0_stb, m1_stb;
  logic [WB_DAT_W-1:0] m0_dat_r, m1_dat_r;
  logic                m0_ack, m1_ack;
  logic                m0_err, m1_err;

  logic                we;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic                stb;
  logic [WB_DAT_W-1:0] dat_r;
  logic                ack;

  // master: controllers and peripheral model; slave: the arbiter itself
  modport master (
    output m0_we, m1_we, m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_stb, m1_stb, dat_r, ack,
    input  m0_dat_r, m1_dat_r, m0_ack, m1_ack, m0_err, m1_err, we, adr, dat_w, stb
  );
  modport slave (
    input  m0_we, m1_we, m0_adr, m1_adr, m0_dat_w, m1_dat_w, m0_stb, m1_stb, dat_r, ack,
    output m0_dat_r, m1_dat_r, m0_ack, m1_ack, m0_err, m1_err, we, adr, dat_w, stb
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-controller Wishbone arbiter, round-robin on contention, one idle cycle between grants.
// Define WB_ARBITER_TIMEOUT_EN to abort grants that wait TIMEOUT_CYCLES without ack.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_wb_we_i,
  input  logic                m1_wb_we_i,
  input  logic [WB_ADR_W-1:0] m0_wb_adr_i,
  input  logic [WB_ADR_W-1:0] m1_wb_adr_i,
  input  logic [WB_DAT_W-1:0] m0_wb_dat_i,
  input  logic [WB_DAT_W-1:0] m1_wb_dat_i,
  input  logic                m0_wb_stb_i,
  input  logic                m1_wb_stb_i,
  output logic [WB_DAT_W-1:0] m0_wb_dat_o,
  output logic [WB_DAT_W-1:0] m1_wb_dat_o,
  output logic                m0_wb_ack_o,
  output logic                m1_wb_ack_o,
  output logic                m0_wb_err_o,
  output logic                m1_wb_err_o,
  output logic                wb_we_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic                wb_stb_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i
);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  arb_state_e state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       gnt0, gnt1, sel_stb, sel_ack, tmo;

  assign gnt0    = (state_q == StGrant0);
  assign gnt1    = (state_q == StGrant1);
  assign sel_stb = (gnt0 & m0_wb_stb_i) | (gnt1 & m1_wb_stb_i);
  assign sel_ack = sel_stb & wb_ack_i;

  // Bus mux: granted controller passes straight through, idle drives zeros
  always_comb begin
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_stb_o = 1'b0;
    if (gnt0) begin
      wb_we_o  = m0_wb_we_i;
      wb_adr_o = m0_wb_adr_i;
      wb_dat_o = m0_wb_dat_i;
      wb_stb_o = m0_wb_stb_i;
    end else if (gnt1) begin
      wb_we_o  = m1_wb_we_i;
      wb_adr_o = m1_wb_adr_i;
      wb_dat_o = m1_wb_dat_i;
      wb_stb_o = m1_wb_stb_i;
    end
  end

  assign m0_wb_ack_o = gnt0 & m0_wb_stb_i & wb_ack_i;
  assign m1_wb_ack_o = gnt1 & m1_wb_stb_i & wb_ack_i;
  assign m0_wb_dat_o = gnt0 ? wb_dat_i : '0;
  assign m1_wb_dat_o = gnt1 ? wb_dat_i : '0;
  assign m0_wb_err_o = gnt0 & tmo;
  assign m1_wb_err_o = gnt1 & tmo;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;

  // Counts completed granted cycles; the cycle that would make it TIMEOUT_CYCLES aborts
  assign tmo = sel_stb & ~wb_ack_i & (tmo_cnt_q == TmoLast);

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == StIdle) tmo_cnt_q <= '0;
    else                            tmo_cnt_q <= tmo_cnt_q + 8'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (m0_wb_stb_i && m1_wb_stb_i) state_d = ptr_q ? StGrant1 : StGrant0;
        else if (m0_wb_stb_i)           state_d = StGrant0;
        else if (m1_wb_stb_i)           state_d = StGrant1;
      end
      StGrant0, StGrant1: begin
        if (!sel_stb) begin
          state_d = StIdle;
        end else if (sel_ack || tmo) begin
          state_d = StIdle;
          ptr_d   = gnt0;  // hand priority to the other controller
        end
      end
      default: state_d = StIdle;
    endcase
  end
endmodule
